// File: rtl/nn_wmem_arbiter.sv
// Round-robin arbiter sharing one weight-memory port between loader write bursts and classifier read bursts.
// Moore FSM: beats start one cycle after the grant decision; one idle bubble separates bursts.
module nn_wmem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [LEN_W-1:0]  ld_len,
  output logic              ld_gnt,
  output logic              ld_beat,
  output logic              ld_done,
  input  logic              cl_req,
  input  logic [ADDR_W-1:0] cl_addr,
  input  logic [LEN_W-1:0]  cl_len,
  output logic              cl_gnt,
  output logic              cl_beat,
  output logic              cl_done,
  output logic              cl_rvalid,
  input  logic              flush,
  output logic [ADDR_W-1:0] MEM_ADD,
  output logic              MEM_WEB,
  output logic              MEM_OEB,
  output logic              MEM_CSB,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LD_BURST, CL_BURST} state_t;

  state_t            state_q;
  logic              rr_last_cl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              ld_gnt_q;
  logic              ld_done_q;
  logic              cl_gnt_q;
  logic              cl_done_q;
  logic              cl_rvalid_q;

  logic              pick_any_d;
  logic              pick_ld_d;
  logic [LEN_W-1:0]  win_len_d;
  logic [ADDR_W-1:0] win_addr_d;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    pick_any_d = ld_req | cl_req;
    pick_ld_d  = ld_req & (~cl_req | rr_last_cl_q);
    win_len_d  = pick_ld_d ? ld_len : cl_len;
    win_addr_d = pick_ld_d ? ld_addr : cl_addr;
    if (win_len_d == '0) begin
      win_len_d = LEN_W'(1);
    end
  end

  // cnt_q holds the beats still to come after the one currently on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_last_cl_q <= 1'b1;
      addr_q       <= '0;
      cnt_q        <= '0;
      ld_gnt_q     <= 1'b0;
      ld_done_q    <= 1'b0;
      cl_gnt_q     <= 1'b0;
      cl_done_q    <= 1'b0;
      cl_rvalid_q  <= 1'b0;
    end else begin
      ld_gnt_q    <= 1'b0;
      ld_done_q   <= 1'b0;
      cl_gnt_q    <= 1'b0;
      cl_done_q   <= 1'b0;
      cl_rvalid_q <= (state_q == CL_BURST);
      case (state_q)
        IDLE: begin
          if (pick_any_d) begin
            state_q      <= pick_ld_d ? LD_BURST : CL_BURST;
            rr_last_cl_q <= ~pick_ld_d;
            addr_q       <= win_addr_d;
            cnt_q        <= win_len_d - LEN_W'(1);
            ld_gnt_q     <= pick_ld_d;
            cl_gnt_q     <= ~pick_ld_d;
            ld_done_q    <= pick_ld_d & (win_len_d == LEN_W'(1));
            cl_done_q    <= ~pick_ld_d & (win_len_d == LEN_W'(1));
          end
        end
        default: begin
          if (flush || cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            addr_q    <= addr_q + ADDR_W'(1);
            cnt_q     <= cnt_q - LEN_W'(1);
            ld_done_q <= (state_q == LD_BURST) && (cnt_q == LEN_W'(1));
            cl_done_q <= (state_q == CL_BURST) && (cnt_q == LEN_W'(1));
          end
        end
      endcase
    end
  end

  assign ld_gnt    = ld_gnt_q;
  assign ld_done   = ld_done_q;
  assign cl_gnt    = cl_gnt_q;
  assign cl_done   = cl_done_q;
  assign cl_rvalid = cl_rvalid_q;
  assign ld_beat   = (state_q == LD_BURST);
  assign cl_beat   = (state_q == CL_BURST);
  assign busy      = ld_beat | cl_beat;
  assign MEM_ADD   = addr_q;
  assign MEM_CSB   = ~busy;
  assign MEM_WEB   = ~ld_beat;
  assign MEM_OEB   = ~cl_beat;

endmodule
